// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Brief    : LC-3b memory-access stage; performs data-memory accesses (LDI/STI in two steps) and holds the MEM/WB pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ex_valid_i,
  input  logic [15:0] ex_intr_i,
  input  logic [15:0] ex_pc_i,
  input  logic [15:0] ex_alu_out_i,
  input  logic [15:0] ex_srcb_i,
  output logic        mem_stall_o,
  output logic        dmem_read_o,
  output logic        dmem_write_o,
  output logic [15:0] dmem_address_o,
  output logic [15:0] dmem_wdata_o,
  output logic [1:0]  dmem_byte_enable_o,
  input  logic [15:0] dmem_rdata_i,
  input  logic        dmem_resp_i,
  output logic        wb_valid_o,
  output logic [15:0] wb_intr_o,
  output logic [15:0] wb_pc_o,
  output logic [15:0] wb_alu_out_o,
  output logic [15:0] wb_data_o
);

  localparam logic [3:0] C_OP_LDB = 4'b0010;
  localparam logic [3:0] C_OP_LDW = 4'b0110;
  localparam logic [3:0] C_OP_LDI = 4'b1010;
  localparam logic [3:0] C_OP_STB = 4'b0011;
  localparam logic [3:0] C_OP_STW = 4'b0111;
  localparam logic [3:0] C_OP_STI = 4'b1011;

  typedef enum logic [0:0] {FIRST = 1'b0, SECOND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:1] ptr_q, ptr_d;

  logic        w_ldb, w_ldw, w_ldi, w_stb, w_stw, w_sti, w_mem, w_done;
  logic [15:0] w_word_addr, w_wb_data;
  logic [7:0]  w_byte;

  assign w_ldb = (ex_intr_i[15:12] == C_OP_LDB);
  assign w_ldw = (ex_intr_i[15:12] == C_OP_LDW);
  assign w_ldi = (ex_intr_i[15:12] == C_OP_LDI);
  assign w_stb = (ex_intr_i[15:12] == C_OP_STB);
  assign w_stw = (ex_intr_i[15:12] == C_OP_STW);
  assign w_sti = (ex_intr_i[15:12] == C_OP_STI);
  assign w_mem = ex_valid_i & (w_ldb | w_ldw | w_ldi | w_stb | w_stw | w_sti);

  assign w_word_addr = {ex_alu_out_i[15:1], 1'b0};

  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    dmem_read_o        = 1'b0;
    dmem_write_o       = 1'b0;
    dmem_address_o     = 16'h0000;
    dmem_wdata_o       = 16'h0000;
    dmem_byte_enable_o = 2'b00;
    w_done             = 1'b0;
    if (!w_mem) begin
      w_done  = 1'b1;
      state_d = FIRST;
    end else if (state_q == FIRST) begin
      if (w_ldi || w_sti) begin
        // Pointer fetch always reads the full word.
        dmem_read_o        = 1'b1;
        dmem_address_o     = w_word_addr;
        dmem_byte_enable_o = 2'b11;
        if (dmem_resp_i) begin
          ptr_d   = dmem_rdata_i[15:1];
          state_d = SECOND;
        end
      end else begin
        dmem_read_o  = w_ldb | w_ldw;
        dmem_write_o = w_stb | w_stw;
        if (w_ldw || w_stw) begin
          dmem_address_o     = w_word_addr;
          dmem_byte_enable_o = 2'b11;
          dmem_wdata_o       = ex_srcb_i;
        end else begin
          dmem_address_o     = ex_alu_out_i;
          dmem_byte_enable_o = ex_alu_out_i[0] ? 2'b10 : 2'b01;
          dmem_wdata_o       = {ex_srcb_i[7:0], ex_srcb_i[7:0]};
        end
        w_done = dmem_resp_i;
      end
    end else begin
      dmem_read_o        = w_ldi;
      dmem_write_o       = w_sti;
      dmem_address_o     = {ptr_q, 1'b0};
      dmem_byte_enable_o = 2'b11;
      dmem_wdata_o       = ex_srcb_i;
      if (dmem_resp_i) begin
        w_done  = 1'b1;
        state_d = FIRST;
      end
    end
    if (reset_i) begin
      dmem_read_o  = 1'b0;
      dmem_write_o = 1'b0;
    end
  end

  assign mem_stall_o = ~reset_i & w_mem & ~w_done;

  assign w_byte = ex_alu_out_i[0] ? dmem_rdata_i[15:8] : dmem_rdata_i[7:0];

  always_comb begin
    w_wb_data = ex_alu_out_i;
    if (w_mem && (w_ldw || w_ldi)) begin
      w_wb_data = dmem_rdata_i;
    end else if (w_mem && w_ldb) begin
      w_wb_data = {{8{w_byte[7]}}, w_byte};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= FIRST;
      ptr_q        <= 15'h0000;
      wb_valid_o   <= 1'b0;
      wb_intr_o    <= 16'h0000;
      wb_pc_o      <= 16'h0000;
      wb_alu_out_o <= 16'h0000;
      wb_data_o    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (w_done) begin
        wb_valid_o   <= ex_valid_i;
        wb_intr_o    <= ex_intr_i;
        wb_pc_o      <= ex_pc_i;
        wb_alu_out_o <= ex_alu_out_i;
        wb_data_o    <= w_wb_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module   : tb_mem_access
// Brief    : Directed self-checking bench for the mem_access stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ex_valid_i;
  logic [15:0] ex_intr_i, ex_pc_i, ex_alu_out_i, ex_srcb_i;
  logic        mem_stall_o, dmem_read_o, dmem_write_o;
  logic [15:0] dmem_address_o, dmem_wdata_o;
  logic [1:0]  dmem_byte_enable_o;
  logic [15:0] dmem_rdata_i;
  logic        dmem_resp_i;
  logic        wb_valid_o;
  logic [15:0] wb_intr_o, wb_pc_o, wb_alu_out_o, wb_data_o;

  int checks = 0;
  int passes = 0;

  mem_access dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .ex_valid_i         (ex_valid_i),
    .ex_intr_i          (ex_intr_i),
    .ex_pc_i            (ex_pc_i),
    .ex_alu_out_i       (ex_alu_out_i),
    .ex_srcb_i          (ex_srcb_i),
    .mem_stall_o        (mem_stall_o),
    .dmem_read_o        (dmem_read_o),
    .dmem_write_o       (dmem_write_o),
    .dmem_address_o     (dmem_address_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_byte_enable_o (dmem_byte_enable_o),
    .dmem_rdata_i       (dmem_rdata_i),
    .dmem_resp_i        (dmem_resp_i),
    .wb_valid_o         (wb_valid_o),
    .wb_intr_o          (wb_intr_o),
    .wb_pc_o            (wb_pc_o),
    .wb_alu_out_o       (wb_alu_out_o),
    .wb_data_o          (wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic v, input logic [15:0] intr, input logic [15:0] alu,
                         input logic [15:0] srcb);
    ex_valid_i   = v;
    ex_intr_i    = intr;
    ex_pc_i      = 16'h0100;
    ex_alu_out_i = alu;
    ex_srcb_i    = srcb;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    present(1'b1, 16'h6000, 16'h1235, 16'h0000);
    dmem_resp_i = 1'b0;
    dmem_rdata_i = 16'h0000;
    step();
    step();
    checks++;
    if (dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0 || mem_stall_o !== 1'b0)
      $display("FAIL reset_strobes: rd=%b wr=%b stall=%b, required 0 0 0", dmem_read_o, dmem_write_o, mem_stall_o);
    else passes++;
    checks++;
    if (wb_valid_o !== 1'b0 || wb_data_o !== 16'h0000 || wb_pc_o !== 16'h0000)
      $display("FAIL reset_wb: valid=%b data=%h pc=%h, required 0 0000 0000", wb_valid_o, wb_data_o, wb_pc_o);
    else passes++;
    reset_i = 1'b0;
    present(1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
  endtask

  task automatic test_ldw();
    int stalls = 0;
    present(1'b1, 16'h6000, 16'h1235, 16'h0000);
    dmem_rdata_i = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      dmem_resp_i = (c == 2);
      #1;
      if (c == 0) begin
        checks++;
        if (dmem_read_o !== 1'b1 || dmem_write_o !== 1'b0 || dmem_address_o !== 16'h1234 || dmem_byte_enable_o !== 2'b11)
          $display("FAIL ldw_req: rd=%b wr=%b addr=%h be=%b, required 1 0 1234 11", dmem_read_o, dmem_write_o, dmem_address_o, dmem_byte_enable_o);
        else passes++;
      end
      if (mem_stall_o) stalls++;
      step();
    end
    dmem_resp_i = 1'b0;
    checks++;
    if (stalls != 2) $display("FAIL ldw_stall_cycles: got %0d, required 2", stalls);
    else passes++;
    checks++;
    if (wb_data_o !== 16'hBEEF || wb_valid_o !== 1'b1 || wb_intr_o !== 16'h6000)
      $display("FAIL ldw_wb: data=%h valid=%b intr=%h, required beef 1 6000", wb_data_o, wb_valid_o, wb_intr_o);
    else passes++;
    present(1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
  endtask

  task automatic test_ldb();
    present(1'b1, 16'h2000, 16'h2001, 16'h0000);
    dmem_rdata_i = 16'h80FF;
    dmem_resp_i = 1'b1;
    #1;
    checks++;
    if (dmem_byte_enable_o !== 2'b10 || dmem_address_o !== 16'h2001 || mem_stall_o !== 1'b0)
      $display("FAIL ldb_hi_req: be=%b addr=%h stall=%b, required 10 2001 0", dmem_byte_enable_o, dmem_address_o, mem_stall_o);
    else passes++;
    step();
    checks++;
    if (wb_data_o !== 16'hFF80) $display("FAIL ldb_hi_data: got %h, required ff80", wb_data_o);
    else passes++;
    present(1'b1, 16'h2000, 16'h2000, 16'h0000);
    #1;
    checks++;
    if (dmem_byte_enable_o !== 2'b01) $display("FAIL ldb_lo_be: got %b, required 01", dmem_byte_enable_o);
    else passes++;
    step();
    checks++;
    if (wb_data_o !== 16'hFFFF) $display("FAIL ldb_lo_data: got %h, required ffff", wb_data_o);
    else passes++;
    dmem_resp_i = 1'b0;
  endtask

  task automatic test_store();
    present(1'b1, 16'h3000, 16'h3001, 16'h12AB);
    dmem_resp_i = 1'b0;
    #1;
    checks++;
    if (dmem_write_o !== 1'b1 || dmem_read_o !== 1'b0 || dmem_wdata_o !== 16'hABAB || dmem_byte_enable_o !== 2'b10)
      $display("FAIL stb_req: wr=%b rd=%b wdata=%h be=%b, required 1 0 abab 10", dmem_write_o, dmem_read_o, dmem_wdata_o, dmem_byte_enable_o);
    else passes++;
    dmem_resp_i = 1'b1;
    step();
    checks++;
    if (wb_data_o !== 16'h3001 || wb_valid_o !== 1'b1)
      $display("FAIL stb_wb: data=%h valid=%b, required 3001 1", wb_data_o, wb_valid_o);
    else passes++;
    present(1'b1, 16'h7000, 16'h3001, 16'h12AB);
    #1;
    checks++;
    if (dmem_write_o !== 1'b1 || dmem_address_o !== 16'h3000 || dmem_byte_enable_o !== 2'b11 || dmem_wdata_o !== 16'h12AB)
      $display("FAIL stw_req: wr=%b addr=%h be=%b wdata=%h, required 1 3000 11 12ab", dmem_write_o, dmem_address_o, dmem_byte_enable_o, dmem_wdata_o);
    else passes++;
    step();
    dmem_resp_i = 1'b0;
  endtask

  task automatic test_ldi();
    int stalls = 0;
    logic [15:0] exp_addr;
    present(1'b1, 16'hA000, 16'h4000, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      dmem_resp_i  = c[0];
      dmem_rdata_i = (c == 1) ? 16'h5000 : 16'h7777;
      exp_addr     = (c < 2) ? 16'h4000 : 16'h5000;
      #1;
      checks++;
      if (dmem_read_o !== 1'b1 || dmem_write_o !== 1'b0 || dmem_address_o !== exp_addr)
        $display("FAIL ldi_req_c%0d: rd=%b wr=%b addr=%h, required 1 0 %h", c, dmem_read_o, dmem_write_o, dmem_address_o, exp_addr);
      else passes++;
      if (mem_stall_o) stalls++;
      step();
    end
    dmem_resp_i = 1'b0;
    checks++;
    if (stalls != 3) $display("FAIL ldi_stall_cycles: got %0d, required 3", stalls);
    else passes++;
    checks++;
    if (wb_data_o !== 16'h7777 || wb_valid_o !== 1'b1)
      $display("FAIL ldi_wb: data=%h valid=%b, required 7777 1", wb_data_o, wb_valid_o);
    else passes++;
  endtask

  task automatic test_sti_reset();
    present(1'b1, 16'hB000, 16'h6002, 16'hCAFE);
    dmem_resp_i  = 1'b1;
    dmem_rdata_i = 16'h6002;
    #1;
    checks++;
    if (dmem_read_o !== 1'b1 || dmem_address_o !== 16'h6002 || dmem_byte_enable_o !== 2'b11)
      $display("FAIL sti_ptr_read: rd=%b addr=%h be=%b, required 1 6002 11", dmem_read_o, dmem_address_o, dmem_byte_enable_o);
    else passes++;
    step();
    dmem_resp_i = 1'b0;
    #1;
    checks++;
    if (dmem_write_o !== 1'b1 || dmem_read_o !== 1'b0 || dmem_address_o !== 16'h6002 ||
        dmem_wdata_o !== 16'hCAFE || dmem_byte_enable_o !== 2'b11 || mem_stall_o !== 1'b1)
      $display("FAIL sti_write: wr=%b rd=%b addr=%h wdata=%h be=%b stall=%b, required 1 0 6002 cafe 11 1",
               dmem_write_o, dmem_read_o, dmem_address_o, dmem_wdata_o, dmem_byte_enable_o, mem_stall_o);
    else passes++;
    checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 16'h7777)
      $display("FAIL sti_wb_hold: valid=%b data=%h, required 1 7777", wb_valid_o, wb_data_o);
    else passes++;
    reset_i = 1'b1;
    #1;
    checks++;
    if (dmem_write_o !== 1'b0 || dmem_read_o !== 1'b0 || mem_stall_o !== 1'b0)
      $display("FAIL sti_reset_drop: wr=%b rd=%b stall=%b, required 0 0 0", dmem_write_o, dmem_read_o, mem_stall_o);
    else passes++;
    step();
    reset_i = 1'b0;
    #1;
    checks++;
    if (wb_valid_o !== 1'b0) $display("FAIL sti_reset_wb: valid=%b, required 0", wb_valid_o);
    else passes++;
    checks++;
    if (dmem_read_o !== 1'b1 || dmem_write_o !== 1'b0 || dmem_address_o !== 16'h6002)
      $display("FAIL sti_restart: rd=%b wr=%b addr=%h, required 1 0 6002", dmem_read_o, dmem_write_o, dmem_address_o);
    else passes++;
    dmem_resp_i = 1'b1;
    step();
    step();
    dmem_resp_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b1 || wb_intr_o !== 16'hB000 || wb_data_o !== 16'h6002)
      $display("FAIL sti_complete: valid=%b intr=%h data=%h, required 1 b000 6002", wb_valid_o, wb_intr_o, wb_data_o);
    else passes++;
  endtask

  task automatic test_add_bubble();
    present(1'b1, 16'h1000, 16'h0042, 16'h0000);
    dmem_resp_i = 1'b1;
    #1;
    checks++;
    if (dmem_read_o !== 1'b0 || dmem_write_o !== 1'b0 || mem_stall_o !== 1'b0)
      $display("FAIL add_no_access: rd=%b wr=%b stall=%b, required 0 0 0", dmem_read_o, dmem_write_o, mem_stall_o);
    else passes++;
    step();
    checks++;
    if (wb_data_o !== 16'h0042 || wb_valid_o !== 1'b1 || wb_pc_o !== 16'h0100 || wb_alu_out_o !== 16'h0042)
      $display("FAIL add_wb: data=%h valid=%b pc=%h alu=%h, required 0042 1 0100 0042", wb_data_o, wb_valid_o, wb_pc_o, wb_alu_out_o);
    else passes++;
    present(1'b0, 16'h6000, 16'h0042, 16'h0000);
    #1;
    checks++;
    if (dmem_read_o !== 1'b0 || mem_stall_o !== 1'b0)
      $display("FAIL bubble_no_access: rd=%b stall=%b, required 0 0", dmem_read_o, mem_stall_o);
    else passes++;
    step();
    dmem_resp_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0) $display("FAIL bubble_wb: valid=%b, required 0", wb_valid_o);
    else passes++;
  endtask

  task automatic test_back_to_back();
    present(1'b1, 16'h6000, 16'h0010, 16'h0000);
    dmem_rdata_i = 16'h1111;
    dmem_resp_i  = 1'b1;
    step();
    present(1'b1, 16'h2000, 16'h0021, 16'h0000);
    dmem_resp_i  = 1'b0;
    #1;
    checks++;
    if (wb_data_o !== 16'h1111 || dmem_read_o !== 1'b1 || dmem_address_o !== 16'h0021 || mem_stall_o !== 1'b1)
      $display("FAIL b2b_second_req: wb=%h rd=%b addr=%h stall=%b, required 1111 1 0021 1", wb_data_o, dmem_read_o, dmem_address_o, mem_stall_o);
    else passes++;
    dmem_rdata_i = 16'h7F00;
    dmem_resp_i  = 1'b1;
    step();
    dmem_resp_i = 1'b0;
    checks++;
    if (wb_data_o !== 16'h007F) $display("FAIL b2b_second_wb: got %h, required 007f", wb_data_o);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_ldw();
    test_ldb();
    test_store();
    test_ldi();
    test_sti_reset();
    test_add_bubble();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
